// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with registered one-hot grant and sticky ownership.
// Optional hold timeout is compiled in with RR_ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt, idx_nxt, sel, off;
    logic [3:0] gnt_nxt, rot;
    logic [7:0] req2;
    logic       expire;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_arbiter_4: HOLD_MAX out of range 1..255");
    end

    // Rotate requests so the pointer client sits at bit 0, then take the lowest set bit.
    assign req2 = {req, req};
    assign rot  = req2[ptr +: 4];
    assign off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign sel  = ptr + off;

    assign gnt_valid = |gnt;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // hold_cnt counts grant cycles already completed in the current ownership.
    assign expire = (hold_cnt == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
            timeout  <= (state == GRANT) && req[gnt_idx] && expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = sel;
                    gnt_nxt   = 4'b0001 << sel;
                end
            end
            GRANT: begin
                // A normal release wins over expiry; both go through IDLE.
                if (!req[gnt_idx] || expire) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    ptr_nxt   = gnt_idx + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            ptr     <= 2'd0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: reset, single client, no preemption, async reset,
// rotation with wrap, and constant-request behaviour (timeout build aware).
module tb_rr_arbiter_4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    rr_arbiter_4 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei, input logic et);
        logic ev;
        ev = |eg;
        checks++;
        assert (gnt === eg) else begin
            failures++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        checks++;
        assert (gnt_idx === ei) else begin
            failures++;
            $error("FAIL %s gnt_idx got=%b exp=%b", tag, gnt_idx, ei);
        end
        checks++;
        assert (gnt_valid === ev) else begin
            failures++;
            $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, ev);
        end
        checks++;
        assert (timeout === et) else begin
            failures++;
            $error("FAIL %s timeout got=%b exp=%b", tag, timeout, et);
        end
    endtask

    initial begin
        logic [3:0] oh;
        logic [1:0] o;

        // Reset held with all requests high
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        chk("rst0", 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst", 4'b0000, 2'd0, 1'b0);
        end

        // Single client 2, four-cycle ownership
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        chk("single_gnt", 4'b0100, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold", 4'b0100, 2'd2, 1'b0);
        end
        req = 4'b0000;
        tick();
        chk("single_rel", 4'b0000, 2'd2, 1'b0);
        req = 4'b1111;
        tick();
        chk("ptr3_gnt", 4'b1000, 2'd3, 1'b0);

        // No preemption by client 0 while client 3 owns
        req = 4'b1000;
        tick();
        chk("nopre_a", 4'b1000, 2'd3, 1'b0);
        req = 4'b1001;
        tick();
        chk("nopre_b", 4'b1000, 2'd3, 1'b0);
        req = 4'b0001;
        tick();
        chk("nopre_rel", 4'b0000, 2'd3, 1'b0);
        tick();
        chk("nopre_next", 4'b0001, 2'd0, 1'b0);

        // Async reset mid-grant clears ptr too
        req = 4'b0000;
        tick();
        chk("async_idle", 4'b0000, 2'd0, 1'b0);
        req = 4'b0100;
        tick();
        chk("async_gnt", 4'b0100, 2'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr", 4'b0000, 2'd0, 1'b0);
        #1 rst_n = 1'b1;
        req = 4'b0110;
        tick();
        chk("async_ptr0", 4'b0010, 2'd1, 1'b0);

        // Rotation and wrap: 2-cycle holds, one-cycle drop of the owner
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            o  = 2'(k % 4);
            oh = 4'b0001 << o;
            tick();
            chk("rot_gnt", oh, o, 1'b0);
            tick();
            chk("rot_hold", oh, o, 1'b0);
            req = 4'b1111 & ~oh;
            tick();
            chk("rot_bubble", 4'b0000, o, 1'b0);
            req = 4'b1111;
        end

        // Constant all-request stimulus
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        chk("const_gnt", 4'b0001, 2'd0, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold0", 4'b0001, 2'd0, 1'b0);
        end
        tick();
        chk("to_pulse0", 4'b0000, 2'd0, 1'b1);
        tick();
        chk("to_gnt1", 4'b0010, 2'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_hold1", 4'b0010, 2'd1, 1'b0);
        end
        tick();
        chk("to_pulse1", 4'b0000, 2'd1, 1'b1);
`else
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("const_hold", 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one resource among four clients. Grants are issued as a registered 2-bit grant index, decoded one-hot (2-to-4 decode, index 0 → bit 0) into the grant vector. It sits in front of any shared datapath that the team selects through a 2-to-4 decoder, and sequences which client owns it. Ownership is held until the owner drops its request, or optionally until a hold timeout.

## Interface
- HOLD_MAX, 8: maximum consecutive grant cycles per ownership; used only when the timeout feature is compiled in; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = client i; level-sensitive.
- gnt  output  4  one-hot grant vector, or 0000 when idle; registered.
- gnt_idx  output  2  binary index of current/last owner; registered.
- gnt_valid  output  1  high while any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when an ownership is forcibly ended; constant 0 without the macro.

## Operation
- Two states: IDLE, GRANT.
- Reset values:
  - state = IDLE, gnt = 0000, gnt_idx = 00, gnt_valid = 0, timeout = 0.
  - Priority pointer ptr = 0; client 0 has highest priority.
- IDLE:
  - If req ≠ 0000, search clients ptr, ptr+1, ptr+2, ptr+3 (mod 4) and select the first one with req set.
  - Next state = GRANT, gnt_idx = selected, gnt = decode(selected).
  - If req = 0000, stay in IDLE; outputs are unchanged except gnt = 0000.
- GRANT:
  - If req[gnt_idx] = 0, go to IDLE, set gnt = 0000, and set ptr = gnt_idx+1 (mod 4; 3 wraps to 0).
  - Otherwise hold the grant. Other clients' requests are ignored; there is no preemption.
- gnt_idx retains the last owner while in IDLE, so it is valid for debug.
- Every release passes through IDLE. This gives one idle (bubble) cycle between consecutive owners, including re-grant to the same client.
- A request that drops while in IDLE before being granted is simply not serviced; there is no latching.

## Timing
- Grant latency: req sampled high on edge N in IDLE → gnt asserted after edge N (visible cycle N+1).
- Release latency: req[owner] sampled low on edge M → gnt = 0000 after edge M.
- Earliest next grant is after edge M+1.
- Minimum ownership is 1 cycle; minimum request-to-request turnaround is 2 cycles.
- rst_n asserted mid-operation:
  - All outputs and ptr clear immediately (asynchronously), without waiting for clk.
  - Operation resumes from IDLE at the first clk edge after rst_n deasserts.
- Simultaneous release and new requests: only the release takes effect on that edge. The new requests are arbitrated on the following edge, using the updated ptr.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - On the edge where the owner has held gnt for HOLD_MAX cycles with req still high, force a transition to IDLE. Set ptr = gnt_idx+1, set gnt = 0000, and pulse timeout high for exactly that one following cycle.
  - A normal release on the same edge as expiry takes priority, with no timeout pulse.
- Not defined:
  - No counter is present and ownership lasts until release.
  - timeout is tied to 0.

## Test plan
- Reset: hold rst_n=0 with req=1111 and clk running → gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0 throughout.
- Single client: req=0100 from cycle 0 → gnt=0100 and gnt_idx=10 from cycle 1. Drop req at cycle 5 → gnt=0000 after that edge. ptr=3, so a following req=1111 grants 1000.
- Rotation and wrap: after reset, each owner drops its req for one cycle after a 2-cycle hold, with all others held high. Grant order must be 0001, 0010, 0100, 1000, 0001, with one 0000 cycle between each.
- Timeout (macro defined, HOLD_MAX=4): req=1111 held constantly → gnt=0001 for exactly 4 cycles, then 0000 with timeout=1, then 0010 for 4 cycles, and so on. Without the macro the same stimulus gives gnt=0001 forever and timeout=0.
- No preemption: the owner is client 3 with req=1000; raise req[0] → gnt stays 1000 until req[3] drops. Then 0000 for one cycle, then 0001.
- Async reset mid-grant: gnt=0100, then pulse rst_n low between clock edges → gnt=0000 immediately. After release with req=0110, the grant is 0010, since ptr has reset to 0.
